// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, dwell-counter debounce FSM,
// one-shot press strobe and auto-repeat strobe train while held.
module btn_debounce_pulse #(
  parameter int CNT_W        = 25,
  parameter int DEBOUNCE_MAX = 1000000,
  parameter int HOLD_MAX     = 25000000,
  parameter int REPEAT_MAX   = 5000000
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic       CCEN,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    INI     = 3'b000,
    WQ      = 3'b001,
    SCEN_ST = 3'b010,
    WH      = 3'b011,
    MCEN_ST = 3'b100,
    CCR     = 3'b101,
    WFCR    = 3'b110
  } state_t;

  localparam logic [CNT_W-1:0] DEB_T = CNT_W'(DEBOUNCE_MAX);
  localparam logic [CNT_W-1:0] HLD_T = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] REP_T = CNT_W'(REPEAT_MAX);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             s2;

  // every state change clears the dwell counter
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= INI;
      cnt   <= '0;
    end else begin
      s1 <= PB;
      s2 <= s1;
      case (state)
        INI: begin
          cnt <= '0;
          if (s2) state <= WQ;
        end
        WQ: begin
          if (!s2) begin
            state <= INI;
            cnt   <= '0;
          end else if (cnt == DEB_T) begin
            state <= SCEN_ST;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCEN_ST: begin
          state <= WH;
          cnt   <= '0;
        end
        WH: begin
          if (!s2) begin
            state <= WFCR;
            cnt   <= '0;
          end else if (cnt == HLD_T) begin
            state <= MCEN_ST;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MCEN_ST: begin
          state <= CCR;
          cnt   <= '0;
        end
        CCR: begin
          if (!s2) begin
            state <= WFCR;
            cnt   <= '0;
          end else if (cnt == REP_T) begin
            state <= MCEN_ST;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WFCR: begin
          if (s2) begin
            state <= WH;
            cnt   <= '0;
          end else if (cnt == DEB_T) begin
            state <= INI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= INI;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign DPB   = (state == SCEN_ST) || (state == WH) ||
                 (state == MCEN_ST) || (state == CCR) ||
                 (state == WFCR);
  assign CCEN  = DPB;
  assign SCEN  = (state == SCEN_ST);
  assign MCEN  = (state == SCEN_ST) || (state == MCEN_ST);
  assign State = state;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with short dwell terminals
// (DEBOUNCE_MAX=4, HOLD_MAX=10, REPEAT_MAX=3, CNT_W=4).
module tb_btn_debounce_pulse;

  logic       board_clk;
  logic       Reset;
  logic       PB;
  logic       DPB;
  logic       SCEN;
  logic       MCEN;
  logic       CCEN;
  logic [2:0] State;

  int checks;
  int errors;

  btn_debounce_pulse #(
    .CNT_W       (4),
    .DEBOUNCE_MAX(4),
    .HOLD_MAX    (10),
    .REPEAT_MAX  (3)
  ) dut (
    .board_clk(board_clk),
    .Reset    (Reset),
    .PB       (PB),
    .DPB      (DPB),
    .SCEN     (SCEN),
    .MCEN     (MCEN),
    .CCEN     (CCEN),
    .State    (State)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int i,
                          input logic e_dpb, input logic e_scen,
                          input logic e_mcen);
    chk($sformatf("%s_dpb_%0d", tag, i), {7'd0, DPB}, {7'd0, e_dpb});
    chk($sformatf("%s_ccen_%0d", tag, i), {7'd0, CCEN}, {7'd0, e_dpb});
    chk($sformatf("%s_scen_%0d", tag, i), {7'd0, SCEN}, {7'd0, e_scen});
    chk($sformatf("%s_mcen_%0d", tag, i), {7'd0, MCEN}, {7'd0, e_mcen});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    PB     = 1'b1;

    // reset held with button pressed
    tick();
    tick();
    chk_outs("rst", 0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", {5'd0, State}, 8'd0);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_outs("t1", i, (i >= 7), (i == 7), (i == 7));
      if (i == 7) chk("t1_state_scen", {5'd0, State}, 8'd2);
    end
    PB = 1'b0;
    repeat (20) tick();
    chk("t1_idle_state", {5'd0, State}, 8'd0);
    chk("t1_idle_dpb", {7'd0, DPB}, 8'd0);

    // glitch pattern: 3 high, 1 low, 3 high, low
    for (int i = 0; i < 15; i++) begin
      PB = (i <= 2) || (i >= 4 && i <= 6);
      tick();
      chk_outs("t2", i, 1'b0, 1'b0, 1'b0);
      if (i == 3) chk("t2_state_wq", {5'd0, State}, 8'd1);
    end
    chk("t2_state_end", {5'd0, State}, 8'd0);

    // short clean press, release, no repeat
    for (int i = 0; i < 26; i++) begin
      PB = (i <= 12);
      tick();
      chk_outs("t3", i, (i >= 7 && i <= 19), (i == 7), (i == 7));
    end
    chk("t3_state_end", {5'd0, State}, 8'd0);

    // long hold with repeats, then release bounce, then clean release
    for (int i = 0; i < 67; i++) begin
      PB = (i <= 46) || (i >= 49 && i <= 55);
      tick();
      chk_outs("t45", i, (i >= 7 && i <= 62), (i == 7),
               (i == 7) || (i >= 19 && i <= 44 && (i - 19) % 5 == 0));
      if (i == 50) chk("t5_state_wfcr", {5'd0, State}, 8'd6);
      if (i == 51) chk("t5_state_wh", {5'd0, State}, 8'd3);
    end
    chk("t5_state_end", {5'd0, State}, 8'd0);

    // asynchronous reset while in repeat-count state
    for (int i = 0; i < 22; i++) begin
      PB = 1'b1;
      tick();
    end
    chk("t6_state_ccr", {5'd0, State}, 8'd5);
    #2;
    Reset = 1'b1;
    #1;
    chk_outs("t6_async", 0, 1'b0, 1'b0, 1'b0);
    chk("t6_async_state", {5'd0, State}, 8'd0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_outs("t6", i, (i >= 7), (i == 7), (i == 7));
    end
    PB = 1'b0;
    repeat (20) tick();
    chk("t6_state_end", {5'd0, State}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
